// File: rtl/serial_mod_checker_if.sv
//------------------------------------------------------------------------------
// Module      : serial_mod_checker_if
// Description : Digit stream in / divisibility result out bundle.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface serial_mod_checker_if #(
    parameter int MOD     = 3,
    parameter int DIGIT_W = 1,
    parameter int LEN_W   = 8
);
    localparam int RW = $clog2(MOD);

    logic               clear;
    logic               in_valid;
    logic [DIGIT_W-1:0] in_digit;
    logic               lsb_first;
    logic               out_valid;
    logic               divisible;
    logic [RW-1:0]      remainder;
    logic [LEN_W-1:0]   digit_count;
    logic               count_sat;

    modport master (
        output clear, in_valid, in_digit, lsb_first,
        input  out_valid, divisible, remainder, digit_count, count_sat
    );

    modport slave (
        input  clear, in_valid, in_digit, lsb_first,
        output out_valid, divisible, remainder, digit_count, count_sat
    );
endinterface

`default_nettype wire

// File: rtl/serial_mod_checker.sv
//------------------------------------------------------------------------------
// Module      : serial_mod_checker
// Description : Streaming divisibility checker, one DIGIT_W digit per beat,
//               MSB-first or LSB-first, reports value-so-far mod MOD.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_mod_checker #(
    parameter int MOD     = 3,
    parameter int DIGIT_W = 1,
    parameter int LEN_W   = 8
) (
    input  wire logic            clk_i,
    input  wire logic            reset_ni,
    serial_mod_checker_if.slave  bus_if
);
    localparam int              RW      = $clog2(MOD);
    localparam int              WW      = RW + DIGIT_W + 1;
    localparam logic [WW-1:0]   MOD_W   = WW'(MOD);
    localparam logic [LEN_W-1:0] CNT_MAX = '1;
    localparam logic [RW-1:0]   W_ONE   = RW'(1);

    logic [RW-1:0]    rem_q, rem_d;
    logic [RW-1:0]    weight_q, weight_d;
    logic             mode_q, mode_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             ov_q, ov_d;
    logic             div_q, div_d;

    logic [RW-1:0]      base_rem, base_w;
    logic [LEN_W-1:0]   base_cnt;
    logic               base_sat;
    logic               first_digit, eff_mode;
    logic [DIGIT_W-1:0] digit;
    logic [WW-1:0]      msb_sum, lsb_sum;
    logic [RW-1:0]      rem_msb, rem_lsb, weight_nxt;

    always_comb begin
        // A clear in the same cycle as a digit restarts the stream first.
        base_rem    = bus_if.clear ? '0    : rem_q;
        base_w      = bus_if.clear ? W_ONE : weight_q;
        base_cnt    = bus_if.clear ? '0    : cnt_q;
        base_sat    = bus_if.clear ? 1'b0  : sat_q;
        first_digit = bus_if.clear || (cnt_q == '0);
        eff_mode    = first_digit ? bus_if.lsb_first : mode_q;
        digit       = bus_if.in_valid ? bus_if.in_digit : '0;

        msb_sum    = (WW'(base_rem) << DIGIT_W) + WW'(digit);
        lsb_sum    = WW'(base_rem) + (WW'(digit) * WW'(base_w));
        rem_msb    = RW'(msb_sum % MOD_W);
        rem_lsb    = RW'(lsb_sum % MOD_W);
        weight_nxt = RW'((WW'(base_w) << DIGIT_W) % MOD_W);

        rem_d    = base_rem;
        weight_d = base_w;
        mode_d   = mode_q;
        cnt_d    = base_cnt;
        sat_d    = base_sat;
        ov_d     = 1'b0;
        div_d    = bus_if.clear ? 1'b1 : div_q;

        if (bus_if.in_valid) begin
            rem_d    = eff_mode ? rem_lsb : rem_msb;
            weight_d = weight_nxt;
            mode_d   = eff_mode;
            cnt_d    = (base_cnt == CNT_MAX) ? CNT_MAX : base_cnt + LEN_W'(1);
            sat_d    = base_sat | (cnt_d == CNT_MAX);
            ov_d     = 1'b1;
            div_d    = (rem_d == '0);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rem_q    <= '0;
            weight_q <= W_ONE;
            mode_q   <= 1'b0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            ov_q     <= 1'b0;
            div_q    <= 1'b1;
        end else begin
            rem_q    <= rem_d;
            weight_q <= weight_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            ov_q     <= ov_d;
            div_q    <= div_d;
        end
    end

    assign bus_if.out_valid   = ov_q;
    assign bus_if.divisible   = div_q;
    assign bus_if.remainder   = rem_q;
    assign bus_if.digit_count = cnt_q;
    assign bus_if.count_sat   = sat_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_mod_checker.sv
//------------------------------------------------------------------------------
// Module      : tb_serial_mod_checker
// Description : Directed bench for serial_mod_checker in three configurations.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_mod_checker;
    typedef struct {
        int rem;
        int dv;
        int cnt;
        int sat;
    } exp_t;

    logic clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    // id 0: MOD3/DW1/LEN8, id 1: MOD5/DW4/LEN8, id 2: MOD7/DW1/LEN3
    serial_mod_checker_if #(.MOD(3), .DIGIT_W(1), .LEN_W(8)) ia ();
    serial_mod_checker_if #(.MOD(5), .DIGIT_W(4), .LEN_W(8)) ib ();
    serial_mod_checker_if #(.MOD(7), .DIGIT_W(1), .LEN_W(3)) ic ();

    serial_mod_checker #(.MOD(3), .DIGIT_W(1), .LEN_W(8)) u_a (
        .clk_i(clk), .reset_ni(reset_n), .bus_if(ia));
    serial_mod_checker #(.MOD(5), .DIGIT_W(4), .LEN_W(8)) u_b (
        .clk_i(clk), .reset_ni(reset_n), .bus_if(ib));
    serial_mod_checker #(.MOD(7), .DIGIT_W(1), .LEN_W(3)) u_c (
        .clk_i(clk), .reset_ni(reset_n), .bus_if(ic));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     MODS [3] = '{3, 5, 7};
    int     DWS  [3] = '{1, 4, 1};
    int     CMAX [3] = '{255, 255, 7};
    longint val  [3];
    int     pos  [3];
    int     cnt  [3];
    int     sat  [3];
    int     mode [3];
    int     hrem [3];
    int     hdiv [3];
    int     hcnt [3];
    int     hsat [3];
    bit     pend [3];
    exp_t   qa[$];
    exp_t   qb[$];
    exp_t   qc[$];

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int id);
        val[id] = 0; pos[id] = 0; cnt[id] = 0; sat[id] = 0; mode[id] = 0;
        hrem[id] = 0; hdiv[id] = 1; hcnt[id] = 0; hsat[id] = 0;
    endtask

    task automatic drive(input int id, input logic v, input int d, input logic lsb, input logic clr);
        case (id)
            0: begin ia.in_valid = v; ia.in_digit = 1'(d); ia.lsb_first = lsb; ia.clear = clr; end
            1: begin ib.in_valid = v; ib.in_digit = 4'(d); ib.lsb_first = lsb; ib.clear = clr; end
            default: begin ic.in_valid = v; ic.in_digit = 1'(d); ic.lsb_first = lsb; ic.clear = clr; end
        endcase
    endtask

    task automatic check_dut(input int id);
        logic [31:0] ov, rm, dv, ct, st;
        exp_t        e;
        case (id)
            0: begin ov = 32'(ia.out_valid); rm = 32'(ia.remainder); dv = 32'(ia.divisible);
                     ct = 32'(ia.digit_count); st = 32'(ia.count_sat); end
            1: begin ov = 32'(ib.out_valid); rm = 32'(ib.remainder); dv = 32'(ib.divisible);
                     ct = 32'(ib.digit_count); st = 32'(ib.count_sat); end
            default: begin ov = 32'(ic.out_valid); rm = 32'(ic.remainder); dv = 32'(ic.divisible);
                     ct = 32'(ic.digit_count); st = 32'(ic.count_sat); end
        endcase
        if (pend[id]) begin
            case (id)
                0: e = qa.pop_front();
                1: e = qb.pop_front();
                default: e = qc.pop_front();
            endcase
            hrem[id] = e.rem; hdiv[id] = e.dv; hcnt[id] = e.cnt; hsat[id] = e.sat;
            pend[id] = 1'b0;
            compare($sformatf("d%0d_out_valid", id), ov, 32'd1);
        end else begin
            compare($sformatf("d%0d_out_valid_idle", id), ov, 32'd0);
        end
        compare($sformatf("d%0d_remainder", id), rm, 32'(hrem[id]));
        compare($sformatf("d%0d_divisible", id), dv, 32'(hdiv[id]));
        compare($sformatf("d%0d_digit_count", id), ct, 32'(hcnt[id]));
        compare($sformatf("d%0d_count_sat", id), st, 32'(hsat[id]));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check_dut(k);
    endtask

    task automatic beat(input int id, input int d, input logic lsb, input logic clr);
        exp_t e;
        if (clr) begin val[id] = 0; pos[id] = 0; cnt[id] = 0; sat[id] = 0; end
        if (cnt[id] == 0) mode[id] = int'(lsb);
        if (mode[id] != 0) val[id] = val[id] + (longint'(d) << (DWS[id] * pos[id]));
        else               val[id] = val[id] * (longint'(1) << DWS[id]) + longint'(d);
        pos[id]++;
        if (cnt[id] < CMAX[id]) cnt[id]++;
        if (cnt[id] == CMAX[id]) sat[id] = 1;
        e.rem = int'(val[id] % longint'(MODS[id]));
        e.dv  = (e.rem == 0) ? 1 : 0;
        e.cnt = cnt[id];
        e.sat = sat[id];
        case (id)
            0: qa.push_back(e);
            1: qb.push_back(e);
            default: qc.push_back(e);
        endcase
        pend[id] = 1'b1;
        drive(id, 1'b1, d, lsb, clr);
        step();
        drive(id, 1'b0, -1, 1'b0, 1'b0);
    endtask

    task automatic clear_only(input int id);
        model_reset(id);
        drive(id, 1'b0, -1, 1'b0, 1'b1);
        step();
        drive(id, 1'b0, -1, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            model_reset(k);
            pend[k] = 1'b0;
            drive(k, 1'b0, -1, 1'b0, 1'b0);
        end
        #12;
        for (int k = 0; k < 3; k++) check_dut(k);
        @(negedge clk);
        reset_n = 1'b1;

        // MSB-first 1,1,0,1 -> remainders 1,0,0,1
        beat(0, 1, 1'b0, 1'b0);
        beat(0, 1, 1'b0, 1'b0);
        beat(0, 0, 1'b0, 1'b0);
        beat(0, 1, 1'b0, 1'b0);
        compare("a_msb_rem", 32'(ia.remainder), 32'd1);
        compare("a_msb_cnt", 32'(ia.digit_count), 32'd4);

        // LSB-first 1,1,0,1 with lsb_first dropped after the first beat
        clear_only(0);
        beat(0, 1, 1'b1, 1'b0);
        beat(0, 1, 1'b0, 1'b0);
        beat(0, 0, 1'b0, 1'b0);
        beat(0, 1, 1'b0, 1'b0);
        compare("a_lsb_rem", 32'(ia.remainder), 32'd2);

        // MOD5 hex digits MSB-first: 7, 0x73, 0x731
        beat(1, 7, 1'b0, 1'b0);
        compare("b_msb_rem0", 32'(ib.remainder), 32'd2);
        beat(1, 3, 1'b0, 1'b0);
        beat(1, 1, 1'b0, 1'b0);
        compare("b_msb_rem2", 32'(ib.remainder), 32'd1);

        // MOD5 hex digits LSB-first: 0x137 = 311
        clear_only(1);
        beat(1, 7, 1'b1, 1'b0);
        beat(1, 3, 1'b0, 1'b0);
        beat(1, 1, 1'b0, 1'b0);
        compare("b_lsb_rem", 32'(ib.remainder), 32'd1);

        // Restart with clear+in_valid, then idle hold, then 1,1
        clear_only(0);
        beat(0, 1, 1'b0, 1'b0);
        beat(0, 0, 1'b0, 1'b0);
        beat(0, 1, 1'b0, 1'b1);
        compare("a_restart_rem", 32'(ia.remainder), 32'd1);
        compare("a_restart_cnt", 32'(ia.digit_count), 32'd1);
        step();
        step();
        beat(0, 1, 1'b0, 1'b0);
        beat(0, 1, 1'b0, 1'b0);
        compare("a_after_hold_rem", 32'(ia.remainder), 32'd1);

        // Build rem=2, count=5 then async reset mid-cycle
        clear_only(0);
        beat(0, 1, 1'b0, 1'b0);
        beat(0, 0, 1'b0, 1'b0);
        beat(0, 0, 1'b0, 1'b0);
        beat(0, 0, 1'b0, 1'b0);
        beat(0, 1, 1'b0, 1'b0);
        compare("a_pre_reset_rem", 32'(ia.remainder), 32'd2);
        compare("a_pre_reset_cnt", 32'(ia.digit_count), 32'd5);
        #2;
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) model_reset(k);
        for (int k = 0; k < 3; k++) check_dut(k);
        @(negedge clk);
        reset_n = 1'b1;
        beat(0, 1, 1'b0, 1'b0);
        compare("a_post_reset_rem0", 32'(ia.remainder), 32'd1);
        beat(0, 1, 1'b0, 1'b0);
        compare("a_post_reset_rem1", 32'(ia.remainder), 32'd0);

        // LEN_W=3 saturation: nine 1-bits = 511 = 7*73
        for (int i = 0; i < 9; i++) begin
            beat(2, 1, 1'b0, 1'b0);
            if (i == 6) compare("c_sat_at_7th", 32'(ic.count_sat), 32'd1);
        end
        compare("c_cnt_sat", 32'(ic.digit_count), 32'd7);
        compare("c_rem_511", 32'(ic.remainder), 32'd0);
        compare("c_div_511", 32'(ic.divisible), 32'd1);
        clear_only(2);
        compare("c_sat_cleared", 32'(ic.count_sat), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
